// File: rtl/spi_draw_queue_pkg.sv
// Shared types and constants for the SPI draw-command queue.
package spi_draw_queue_pkg;
    `include "params.vh"

    localparam int SPRITE_W = (SPRITE_NUM > 1) ? $clog2(SPRITE_NUM) : 1;

    localparam logic [1:0] ST_CMD     = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_SKIP    = 2'd2;

    typedef struct packed {
        logic [SPRITE_W-1:0] sprite;
        logic [15:0]         x;
        logic [15:0]         y;
        logic [7:0]          flags;
    } draw_entry_t;
endpackage

// File: rtl/draw_fifo.sv
// First-word-fall-through FIFO of draw entries with a sticky drop flag.
module draw_fifo
    import spi_draw_queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  draw_entry_t            push_data,
    output logic                   full,
    input  logic                   pop,
    output draw_entry_t            pop_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    draw_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          do_push;
    logic          do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign do_push  = push & (~full | do_pop);
    assign count    = cnt;
    assign overflow = ovf;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (push && !do_push) begin
                ovf <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/params.vh
// Command byte values and sprite table size shared by the SPI command parser.
`ifndef SPI_DRAW_QUEUE_PARAMS_VH
`define SPI_DRAW_QUEUE_PARAMS_VH
localparam logic [7:0] COMMAND_DRAW_SPRITE = 8'hA1;
localparam logic [7:0] COMMAND_SAVE_SPRITE = 8'hA2;
localparam int         SPRITE_NUM          = 64;
`endif

// File: rtl/spi_draw_queue.sv
// Parses SPI draw/save commands from an asynchronous byte strobe and queues draw entries.
module spi_draw_queue
    import spi_draw_queue_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int SKIP_SAVE_LEN = 513
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   data_clk,
    input  logic [7:0]             data,
    output logic                   draw_valid,
    input  logic                   draw_ready,
    output logic [SPRITE_W-1:0]    draw_sprite,
    output logic [15:0]            draw_x,
    output logic [15:0]            draw_y,
    output logic [7:0]             draw_flags,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   overflow,
    output logic [1:0]             fsm_state
);
    localparam int CNT_W = $clog2(SKIP_SAVE_LEN + 1);

    logic                en_s1, en_s2;
    logic                dc_s1, dc_s2, dc_prev;
    logic [1:0]          state;
    logic [2:0]          idx;
    logic [CNT_W-1:0]    skip_cnt;
    logic [SPRITE_W-1:0] sprite_r;
    logic [15:0]         x_r;
    logic [15:0]         y_r;
    logic                byte_evt;
    logic                push;
    logic                full;
    logic                empty;
    draw_entry_t         push_entry;
    draw_entry_t         head;

    // One byte per falling edge of the synchronised strobe; data has been stable since it fell.
    assign byte_evt  = dc_prev & ~dc_s2;
    assign push      = byte_evt & en_s2 & (state == ST_COLLECT) & (idx == 3'd5);
    assign fsm_state = state;

    always_comb begin
        push_entry        = '0;
        push_entry.sprite = sprite_r;
        push_entry.x      = x_r;
        push_entry.y      = y_r;
        push_entry.flags  = data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            en_s1    <= 1'b0;
            en_s2    <= 1'b0;
            dc_s1    <= 1'b0;
            dc_s2    <= 1'b0;
            dc_prev  <= 1'b0;
            state    <= ST_CMD;
            idx      <= '0;
            skip_cnt <= '0;
            sprite_r <= '0;
            x_r      <= '0;
            y_r      <= '0;
        end else begin
            en_s1   <= enable;
            en_s2   <= en_s1;
            dc_s1   <= data_clk;
            dc_s2   <= dc_s1;
            dc_prev <= dc_s2;
            if (!en_s2) begin
                state    <= ST_CMD;
                idx      <= '0;
                skip_cnt <= '0;
            end else if (byte_evt) begin
                case (state)
                    ST_CMD: begin
                        if (data == COMMAND_DRAW_SPRITE) begin
                            state <= ST_COLLECT;
                            idx   <= '0;
                        end else if (data == COMMAND_SAVE_SPRITE) begin
                            state    <= ST_SKIP;
                            skip_cnt <= CNT_W'(SKIP_SAVE_LEN);
                        end
                    end
                    ST_COLLECT: begin
                        idx <= idx + 3'd1;
                        case (idx)
                            3'd0: sprite_r   <= data[SPRITE_W-1:0];
                            3'd1: x_r[15:8]  <= data;
                            3'd2: x_r[7:0]   <= data;
                            3'd3: y_r[15:8]  <= data;
                            3'd4: y_r[7:0]   <= data;
                            default: begin
                                state <= ST_CMD;
                                idx   <= '0;
                            end
                        endcase
                    end
                    ST_SKIP: begin
                        skip_cnt <= skip_cnt - CNT_W'(1);
                        if (skip_cnt <= CNT_W'(1)) begin
                            state <= ST_CMD;
                        end
                    end
                    default: state <= ST_CMD;
                endcase
            end
        end
    end

    draw_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .full      (full),
        .pop       (draw_ready),
        .pop_data  (head),
        .empty     (empty),
        .count     (queue_count),
        .overflow  (overflow)
    );

    assign draw_valid  = ~empty;
    assign draw_sprite = head.sprite;
    assign draw_x      = head.x;
    assign draw_y      = head.y;
    assign draw_flags  = head.flags;
endmodule

// File: tb/tb_spi_draw_queue.sv
// Bench for spi_draw_queue: SPI byte driver, queue-level expected model, per-scenario tests.
module tb_spi_draw_queue;
    import spi_draw_queue_pkg::*;

    localparam int DEPTH    = 16;
    localparam int SKIP_LEN = 513;
    localparam int W        = $bits(draw_entry_t);

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   enable = 1'b0;
    logic                   data_clk = 1'b0;
    logic [7:0]             data = 8'h00;
    logic                   draw_valid;
    logic                   draw_ready = 1'b0;
    logic [SPRITE_W-1:0]    draw_sprite;
    logic [15:0]            draw_x;
    logic [15:0]            draw_y;
    logic [7:0]             draw_flags;
    logic [$clog2(DEPTH):0] queue_count;
    logic                   overflow;
    logic [1:0]             fsm_state;

    int             checks = 0;
    int             errors = 0;
    logic [W-1:0]   exp_q[$];
    bit             exp_ovf = 0;
    bit             ready_hook = 0;
    logic           last_v_t2, last_v_t3;

    spi_draw_queue #(.DEPTH(DEPTH), .SKIP_SAVE_LEN(SKIP_LEN)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .data_clk    (data_clk),
        .data        (data),
        .draw_valid  (draw_valid),
        .draw_ready  (draw_ready),
        .draw_sprite (draw_sprite),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_flags  (draw_flags),
        .queue_count (queue_count),
        .overflow    (overflow),
        .fsm_state   (fsm_state)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] make_entry(input logic [7:0] s, input logic [15:0] x,
                                                input logic [15:0] y, input logic [7:0] f);
        draw_entry_t e;
        e.sprite = s[SPRITE_W-1:0];
        e.x      = x;
        e.y      = y;
        e.flags  = f;
        return e;
    endfunction

    task automatic model_push(input logic [W-1:0] e);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_ovf = 1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_ovf = 0;
    endtask

    // Strobe high, then data, then fall; t2/t3 are the cycles just before/after the byte takes effect.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        data_clk = 1'b1;
        @(negedge clock);
        data = b;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        data_clk = 1'b0;
        @(negedge clock);
        @(negedge clock);
        last_v_t2 = draw_valid;
        if (ready_hook) draw_ready = 1'b1;
        @(negedge clock);
        last_v_t3 = draw_valid;
        if (ready_hook) draw_ready = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clock);
    endtask

    task automatic send_draw(input logic [7:0] s, input logic [15:0] x, input logic [15:0] y,
                             input logic [7:0] f, input bit coincide);
        send_byte(COMMAND_DRAW_SPRITE);
        send_byte(s);
        send_byte(x[15:8]);
        send_byte(x[7:0]);
        send_byte(y[15:8]);
        send_byte(y[7:0]);
        ready_hook = coincide;
        send_byte(f);
        ready_hook = 0;
        if (coincide) void'(exp_q.pop_front());
        if (coincide) exp_q.push_back(make_entry(s, x, y, f));
        else model_push(make_entry(s, x, y, f));
    endtask

    task automatic set_enable(input logic v);
        @(negedge clock);
        enable = v;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({draw_valid, queue_count, overflow, draw_sprite, draw_x, draw_y, draw_flags, fsm_state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b count=%0d ovf=%b head=%h state=%0d required all 0",
                     draw_valid, queue_count, overflow, {draw_sprite, draw_x, draw_y, draw_flags}, fsm_state);
        end
        reset = 1'b0;
        model_clear();
        set_enable(1'b1);
    endtask

    task automatic test_single_draw();
        send_draw(8'h03, 16'd300, 16'd200, 8'h05, 0);
        checks++;
        if (last_v_t2 !== 1'b0 || last_v_t3 !== 1'b1) begin
            errors++;
            $display("FAIL t1_valid_timing got %b%b required 01", last_v_t2, last_v_t3);
        end
        checks++;
        if (draw_sprite !== SPRITE_W'(3) || draw_x !== 16'd300 || draw_y !== 16'd200 ||
            draw_flags !== 8'h05 || queue_count !== 1) begin
            errors++;
            $display("FAIL t1_entry got sprite=%0d x=%0d y=%0d flags=%h count=%0d required 3 300 200 05 1",
                     draw_sprite, draw_x, draw_y, draw_flags, queue_count);
        end
        draw_ready = 1'b1;
        @(negedge clock);
        draw_ready = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (draw_valid !== 1'b0 || queue_count !== 0) begin
            errors++;
            $display("FAIL t1_pop got valid=%b count=%0d required 0 0", draw_valid, queue_count);
        end
    endtask

    task automatic test_save_skip();
        logic [7:0] b;
        send_byte(COMMAND_SAVE_SPRITE);
        for (int i = 0; i < SKIP_LEN; i++) begin
            b = 8'($urandom);
            if (i % 50 == 0) b = COMMAND_DRAW_SPRITE;
            if (i % 77 == 1) b = COMMAND_SAVE_SPRITE;
            if (i == SKIP_LEN - 1) begin
                checks++;
                if (fsm_state !== ST_SKIP) begin
                    errors++;
                    $display("FAIL t2_still_skip got %0d required %0d", fsm_state, ST_SKIP);
                end
            end
            send_byte(b);
        end
        checks++;
        if (fsm_state !== ST_CMD || queue_count !== 0) begin
            errors++;
            $display("FAIL t2_skip_end got state=%0d count=%0d required %0d 0", fsm_state, queue_count, ST_CMD);
        end
        send_draw(8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 0);
        checks++;
        if (queue_count !== 1) begin
            errors++;
            $display("FAIL t2_count got %0d required 1", queue_count);
        end
        begin
            int n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                checks++;
                if (draw_valid !== 1'b1 || {draw_sprite, draw_x, draw_y, draw_flags} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL t2_head got %b/%h required 1/%h", draw_valid,
                             {draw_sprite, draw_x, draw_y, draw_flags}, exp_q[0]);
                end
                void'(exp_q.pop_front());
                draw_ready = 1'b1;
                @(negedge clock);
            end
            draw_ready = 1'b0;
        end
    endtask

    task automatic test_abort_enable();
        send_byte(COMMAND_DRAW_SPRITE);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        set_enable(1'b0);
        checks++;
        if (fsm_state !== ST_CMD) begin
            errors++;
            $display("FAIL t3_abort_state got %0d required %0d", fsm_state, ST_CMD);
        end
        send_byte(COMMAND_DRAW_SPRITE);
        set_enable(1'b1);
        send_draw(8'h2A, 16'h0456, 16'h0789, 8'hC3, 0);
        checks++;
        if (queue_count !== 1) begin
            errors++;
            $display("FAIL t3_count got %0d required 1", queue_count);
        end
        begin
            int n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                checks++;
                if (draw_valid !== 1'b1 || {draw_sprite, draw_x, draw_y, draw_flags} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL t3_head got %b/%h required 1/%h", draw_valid,
                             {draw_sprite, draw_x, draw_y, draw_flags}, exp_q[0]);
                end
                void'(exp_q.pop_front());
                draw_ready = 1'b1;
                @(negedge clock);
            end
            draw_ready = 1'b0;
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_draw(8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 0);
        end
        checks++;
        if (queue_count !== DEPTH || overflow !== exp_ovf || exp_ovf !== 1'b1) begin
            errors++;
            $display("FAIL t4_full got count=%0d ovf=%b required %0d 1", queue_count, overflow, DEPTH);
        end
        begin
            int n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                checks++;
                if (draw_valid !== 1'b1 || {draw_sprite, draw_x, draw_y, draw_flags} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL t4_order[%0d] got %b/%h required 1/%h", i, draw_valid,
                             {draw_sprite, draw_x, draw_y, draw_flags}, exp_q[0]);
                end
                void'(exp_q.pop_front());
                draw_ready = 1'b1;
                @(negedge clock);
            end
            draw_ready = 1'b0;
        end
        checks++;
        if (queue_count !== 0 || draw_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL t4_drained got count=%0d valid=%b ovf=%b required 0 0 1",
                     queue_count, draw_valid, overflow);
        end
    endtask

    task automatic test_reset_mid_collect();
        send_draw(8'h01, 16'd10, 16'd20, 8'h30, 0);
        send_draw(8'h02, 16'd40, 16'd50, 8'h60, 0);
        send_byte(COMMAND_DRAW_SPRITE);
        send_byte(8'h07);
        send_byte(8'h01);
        checks++;
        if (fsm_state !== ST_COLLECT || queue_count !== 2) begin
            errors++;
            $display("FAIL t6_pre got state=%0d count=%0d required %0d 2", fsm_state, queue_count, ST_COLLECT);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({draw_valid, queue_count, overflow, draw_sprite, draw_x, draw_y, draw_flags, fsm_state} !== '0) begin
            errors++;
            $display("FAIL t6_reset got valid=%b count=%0d ovf=%b head=%h state=%0d required all 0",
                     draw_valid, queue_count, overflow, {draw_sprite, draw_x, draw_y, draw_flags}, fsm_state);
        end
        reset = 1'b0;
        model_clear();
        repeat (4) @(negedge clock);
        send_draw(8'h09, 16'h1234, 16'h5678, 8'h9A, 0);
        checks++;
        if (queue_count !== 1 || draw_valid !== 1'b1 ||
            {draw_sprite, draw_x, draw_y, draw_flags} !== exp_q[0]) begin
            errors++;
            $display("FAIL t6_after got count=%0d head=%h required 1 %h", queue_count,
                     {draw_sprite, draw_x, draw_y, draw_flags}, exp_q[0]);
        end
        draw_ready = 1'b1;
        @(negedge clock);
        draw_ready = 1'b0;
        void'(exp_q.pop_front());
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) begin
            send_draw(8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 0);
        end
        send_draw(8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 1);
        checks++;
        if (queue_count !== DEPTH || overflow !== 1'b0) begin
            errors++;
            $display("FAIL t5_full got count=%0d ovf=%b required %0d 0", queue_count, overflow, DEPTH);
        end
        begin
            int n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                checks++;
                if (draw_valid !== 1'b1 || {draw_sprite, draw_x, draw_y, draw_flags} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL t5_order[%0d] got %b/%h required 1/%h", i, draw_valid,
                             {draw_sprite, draw_x, draw_y, draw_flags}, exp_q[0]);
                end
                void'(exp_q.pop_front());
                draw_ready = 1'b1;
                @(negedge clock);
            end
            draw_ready = 1'b0;
        end
    endtask

    task automatic test_random_mix();
        int n_cmd = $urandom_range(3, DEPTH + 3);
        logic [7:0] junk;
        for (int i = 0; i < n_cmd; i++) begin
            junk = 8'($urandom);
            if (junk == COMMAND_DRAW_SPRITE || junk == COMMAND_SAVE_SPRITE) junk = 8'h00;
            if ($urandom_range(0, 2) == 0) send_byte(junk);
            send_draw(8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 0);
        end
        checks++;
        if (queue_count !== exp_q.size() || overflow !== exp_ovf) begin
            errors++;
            $display("FAIL rnd_count got count=%0d ovf=%b required %0d %b", queue_count, overflow,
                     exp_q.size(), exp_ovf);
        end
        begin
            int n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                checks++;
                if (draw_valid !== 1'b1 || {draw_sprite, draw_x, draw_y, draw_flags} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rnd_order[%0d] got %b/%h required 1/%h", i, draw_valid,
                             {draw_sprite, draw_x, draw_y, draw_flags}, exp_q[0]);
                end
                void'(exp_q.pop_front());
                draw_ready = 1'b1;
                @(negedge clock);
            end
            draw_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_draw();
        test_save_skip();
        test_abort_enable();
        test_overflow();
        test_reset_mid_collect();
        test_full_push_pop();
        test_random_mix();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
